// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier; latency PIPE_STAGES+1 edges from acceptance, one result per cycle.
// Whole-pipeline stall: in_ready = !out_valid | out_ready. Define WALLACE_MULT_SIGNED_EN for Baugh-Wooley signed mode.
module wallace_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
`ifdef WALLACE_MULT_SIGNED_EN
    localparam int NPP = WIDTH + 1;
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`else
    localparam int NPP = WIDTH;
`endif

    function automatic int tree_layers(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int NL = tree_layers(NPP);

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // One row of full adders: three rows in, sum row and left-shifted carry row out.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [1:0]    r;
        s = '0;
        c = '0;
        for (int k = 0; k < PW; k++) begin
            r    = fa(x[k], y[k], z[k]);
            s[k] = r[0];
            if (k < PW - 1) c[k+1] = r[1];
        end
        return {c, s};
    endfunction

    // Ripple CPA; the carry out of the top bit is dropped because the product fits in PW bits.
    function automatic logic [PW-1:0] cpa(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] s;
        logic          c;
        logic [1:0]    r;
        s    = '0;
        r    = ha(x[0], y[0]);
        s[0] = r[0];
        c    = r[1];
        for (int k = 1; k < PW; k++) begin
            r    = fa(x[k], y[k], c);
            s[k] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    logic             adv;
    logic             s0_vld;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic [PW-1:0]    row_x;
    logic [PW-1:0]    row_y;
    logic             out_vld_q;
    logic [PW-1:0]    out_dat_q;
    logic             mid_busy;

    assign adv         = !out_vld_q || out_ready;
    assign in_ready    = adv && rst_n;
    assign out_valid   = out_vld_q;
    assign out_product = out_dat_q;
    assign busy        = s0_vld || mid_busy || out_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
            s0_a   <= '0;
            s0_b   <= '0;
        end else if (adv) begin
            s0_vld <= in_valid;
            s0_a   <= in_a;
            s0_b   <= in_b;
        end
    end

    always_comb begin
        logic [PW-1:0]    tree [0:NL][0:NPP-1];
        logic [WIDTH-1:0] pp;
        logic [2*PW-1:0]  cs;
        logic             pbit;
        int               n;
        int               g3;
        for (int l = 0; l <= NL; l++)
            for (int r = 0; r < NPP; r++)
                tree[l][r] = '0;
        pp   = '0;
        cs   = '0;
        pbit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pbit = s0_a[j] & s0_b[i];
`ifdef WALLACE_MULT_SIGNED_EN
                // Baugh-Wooley: terms mixing exactly one sign bit are inverted.
                if ((i == WIDTH - 1) != (j == WIDTH - 1)) pbit = ~pbit;
`endif
                pp[j] = pbit;
            end
            tree[0][i] = PW'(pp) << i;
        end
`ifdef WALLACE_MULT_SIGNED_EN
        tree[0][WIDTH] = BW_CORR;
`endif
        n = NPP;
        for (int l = 0; l < NL; l++) begin
            g3 = n / 3;
            for (int g = 0; g < NPP / 3; g++) begin
                if (g < g3) begin
                    cs = csa(tree[l][3*g], tree[l][3*g+1], tree[l][3*g+2]);
                    tree[l+1][2*g]   = cs[PW-1:0];
                    tree[l+1][2*g+1] = cs[2*PW-1:PW];
                end
            end
            // Rows left over from the groups of three pass straight to the next layer.
            for (int r = 0; r < NPP; r++) begin
                if (r >= 3 * g3 && r < n) tree[l+1][r-g3] = tree[l][r];
            end
            n = 2 * g3 + n % 3;
        end
        row_x = tree[NL][0];
        row_y = tree[NL][1];
    end

    generate
        if (PIPE_STAGES == 1) begin : g_one
            assign mid_busy = 1'b0;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_vld_q <= 1'b0;
                    out_dat_q <= '0;
                end else if (adv) begin
                    out_vld_q <= s0_vld;
                    out_dat_q <= cpa(row_x, row_y);
                end
            end
        end else begin : g_multi
            // First boundary sits between the CSA tree and the CPA; the rest delay the product.
            logic                   s1_vld;
            logic [PW-1:0]          s1_x;
            logic [PW-1:0]          s1_y;
            logic [PIPE_STAGES:2]   vld;
            logic [PW-1:0]          dat [PIPE_STAGES:2];

            assign mid_busy  = s1_vld || (|vld);
            assign out_vld_q = vld[PIPE_STAGES];
            assign out_dat_q = dat[PIPE_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld <= 1'b0;
                    s1_x   <= '0;
                    s1_y   <= '0;
                    vld    <= '0;
                    for (int k = 2; k <= PIPE_STAGES; k++) dat[k] <= '0;
                end else if (adv) begin
                    s1_vld <= s0_vld;
                    s1_x   <= row_x;
                    s1_y   <= row_y;
                    vld[2] <= s1_vld;
                    dat[2] <= cpa(s1_x, s1_y);
                    for (int k = 3; k <= PIPE_STAGES; k++) begin
                        vld[k] <= vld[k-1];
                        dat[k] <= dat[k-1];
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: 8-bit/2-stage instance for directed scenarios, 16-bit/4-stage for a random sweep.
module tb_wallace_mult_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_product;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [15:0] w_in_a, w_in_b;
    logic [31:0] w_out_product;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] q8 [$];
    logic [31:0] q16 [$];

    wallace_mult_pipe #(.WIDTH(8), .PIPE_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .busy(busy));

    wallace_mult_pipe #(.WIDTH(16), .PIPE_STAGES(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_product(w_out_product), .busy(w_busy));

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
`ifdef WALLACE_MULT_SIGNED_EN
        logic [15:0] x = {{8{a[7]}}, a};
        logic [15:0] y = {{8{b[7]}}, b};
`else
        logic [15:0] x = {8'h00, a};
        logic [15:0] y = {8'h00, b};
`endif
        return x * y;
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
`ifdef WALLACE_MULT_SIGNED_EN
        logic [31:0] x = {{16{a[15]}}, a};
        logic [31:0] y = {{16{b[15]}}, b};
`else
        logic [31:0] x = {16'h0000, a};
        logic [31:0] y = {16'h0000, b};
`endif
        return x * y;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (out_product !== 16'h0) begin n_bad++; $display("FAIL rst_product: got %h want 0000", out_product); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
        // Two operations in flight, then reset hits asynchronously.
        in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05;
        @(negedge clk) begin in_a = 8'h07; in_b = 8'h09; end
        @(negedge clk) in_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL inflight_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (out_product !== 16'h0) begin n_bad++; $display("FAIL midrst_product: got %h want 0000", out_product); end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL stale_after_reset: cycle %0d out_valid %b busy %b want 0 0", c, out_valid, busy);
            end
        end
    endtask

    task automatic test_single;
        logic [15:0] want;
`ifdef WALLACE_MULT_SIGNED_EN
        want = 16'h0001;
`else
        want = 16'hFE01;
`endif
        @(negedge clk) begin in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; out_ready = 1'b1; end
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: out_valid %b want 0 after edge 1", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: out_valid %b want 1 after edge 2", out_valid); end
        n_cmp++; if (out_product !== want) begin n_bad++; $display("FAIL single_product: got %h want %h", out_product, want); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_consumed: busy %b out_valid %b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        logic [15:0] exp;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 16); in_a = 8'(sent); in_b = 8'(sent + 3); out_ready = 1'b1;
            #1;
            if (sent < 16) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_cmp++;
                if (q8.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra: unexpected result %h", out_product);
                end else begin
                    exp = q8.pop_front();
                    if (out_product !== exp) begin n_bad++; $display("FAIL b2b_result %0d: got %h want %h", got, out_product, exp); end
                end
                got++;
            end
            if (in_valid && in_ready) begin q8.push_back(ref8(in_a, in_b)); sent++; end
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 16) begin n_bad++; $display("FAIL b2b_count: got %0d want 16", got); end
        n_cmp++; if (last - first !== 15) begin n_bad++; $display("FAIL b2b_rate: span %0d want 15", last - first); end
    endtask

    task automatic test_backpressure;
        int stalled = 0;
        int got = 0;
        logic [15:0] held;
        logic [15:0] exp;
        held = '0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 8'(8'h10 + cyc); in_b = 8'(8'h21 + 7 * cyc); out_ready = 1'b0;
            #1;
            if (out_valid) begin
                if (stalled == 0) begin
                    held = out_product;
                    n_cmp++; if (q8.size() == 0 || held !== q8[0]) begin n_bad++; $display("FAIL bp_head: got %h", held); end
                end
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                n_cmp++; if (out_product !== held) begin n_bad++; $display("FAIL bp_hold: got %h want %h", out_product, held); end
                stalled++;
            end
            if (in_valid && in_ready) q8.push_back(ref8(in_a, in_b));
        end
        n_cmp++; if (stalled !== 5) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stalled); end
        for (int cyc = 0; cyc < 20 && q8.size() > 0; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                exp = q8.pop_front();
                n_cmp++; if (out_product !== exp) begin n_bad++; $display("FAIL bp_drain %0d: got %h want %h", got, out_product, exp); end
                got++;
            end
        end
        n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 3", got); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dup: busy %b out_valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_boundary;
        logic [7:0]  ta [4];
        logic [7:0]  tb [4];
        logic [15:0] te [4];
        logic [15:0] exp;
        int sent = 0;
        int got = 0;
`ifdef WALLACE_MULT_SIGNED_EN
        ta = '{8'h80, 8'hFF, 8'h7F, 8'hFF};
        tb = '{8'h80, 8'h01, 8'h80, 8'hFF};
        te = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0001};
`else
        ta = '{8'h00, 8'h01, 8'h80, 8'hFF};
        tb = '{8'hAB, 8'hAB, 8'h02, 8'hFF};
        te = '{16'h0000, 16'h00AB, 16'h0100, 16'hFE01};
`endif
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 4);
            in_a = (sent < 4) ? ta[sent] : 8'h00;
            in_b = (sent < 4) ? tb[sent] : 8'h00;
            out_ready = (($urandom_range(0, 2)) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q8.size() == 0) begin
                    n_bad++; $display("FAIL bnd_extra: unexpected result %h", out_product);
                end else begin
                    exp = q8.pop_front();
                    if (out_product !== exp) begin n_bad++; $display("FAIL bnd_vec %0d: got %h want %h", got, out_product, exp); end
                end
                got++;
            end
            if (in_valid && in_ready) begin q8.push_back(te[sent]); sent++; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL bnd_count: got %0d want 4", got); end
    endtask

    task automatic test_wide_sweep;
        int sent = 0;
        int got = 0;
        logic [31:0] exp;
        for (int cyc = 0; cyc < 3000 && got < 150; cyc++) begin
            @(negedge clk);
            if (sent < 150) begin
                case (sent)
                    0: begin w_in_a = 16'hFFFF; w_in_b = 16'hFFFF; end
                    1: begin w_in_a = 16'h8000; w_in_b = 16'h8000; end
                    2: begin w_in_a = 16'h0000; w_in_b = 16'h1234; end
                    3: begin w_in_a = 16'h0001; w_in_b = 16'hFFFF; end
                    4: begin w_in_a = 16'h7FFF; w_in_b = 16'h8000; end
                    default: begin w_in_a = 16'($urandom); w_in_b = 16'($urandom); end
                endcase
                w_in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                w_in_valid = 1'b0;
            end
            w_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (w_out_valid && w_out_ready) begin
                n_cmp++;
                if (q16.size() == 0) begin
                    n_bad++; $display("FAIL wide_extra: unexpected result %h", w_out_product);
                end else begin
                    exp = q16.pop_front();
                    if (w_out_product !== exp) begin n_bad++; $display("FAIL wide_result %0d: got %h want %h", got, w_out_product, exp); end
                end
                got++;
            end
            if (w_in_valid && w_in_ready) begin q16.push_back(ref16(w_in_a, w_in_b)); sent++; end
        end
        w_in_valid = 1'b0; w_out_ready = 1'b1;
        n_cmp++; if (got !== 150) begin n_bad++; $display("FAIL wide_count: got %0d want 150", got); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_boundary();
        test_wide_sweep();
        n_cmp++; if (q8.size() != 0 || q16.size() != 0) begin
            n_bad++; $display("FAIL leftover: q8 %0d q16 %0d want 0 0", q8.size(), q16.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier built from the team's half/full-adder cells.
- Successor to the combinational adder cells: multiplies two WIDTH-bit operands through registered carry-save reduction stages and a final carry-propagate adder.
- Uses a valid/ready handshake on input and output, with a whole-pipeline stall, so it drops into streaming datapaths.

Parameters:
- WIDTH, 8, operand width in bits (legal 4..32); product is 2*WIDTH bits.
- PIPE_STAGES, 2, number of register boundaries after the input register (legal 1..4); sets latency.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands on in_a/in_b are valid.
- in_ready  output  1  block can accept operands this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- out_valid  output  1  out_product holds a result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_product  output  2*WIDTH  product.
- busy  output  1  any pipeline slot holds a valid operation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: while rst_n=0, every valid bit is 0, out_valid=0, out_product=0, busy=0, in_ready=0.
  - in_ready returns to 1 in the first cycle after rst_n deasserts.
- Reset mid-operation: all in-flight results are discarded; none emerges after reset.
- Structure:
  - Input register: stage 0.
  - Partial-product generation: AND array.
  - Wallace reduction: layers of 3:2 full adders and 2:2 half adders, down to two rows.
  - Final carry-propagate adder: 2*WIDTH bits.
  - Output register: last stage.
- Register placement: the PIPE_STAGES boundaries may be placed anywhere in the reduction/CPA path. The latency contract below is fixed.
- Advance enable: adv = !out_valid | out_ready.
  - in_ready = adv (combinational).
  - All stages, including valid bits, load only when adv=1.
  - When adv=0, every stage holds.
- Acceptance: a transfer occurs on an edge where in_valid & in_ready.
  - If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Latency: operands accepted at edge E appear with out_valid=1 after edge E+PIPE_STAGES, i.e. PIPE_STAGES+1 edges counting E, provided no stall occurs.
  - Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle when out_ready is held at 1.
- Output hold: while out_valid=1 and out_ready=0, out_product and out_valid are stable.
- Simultaneous events: new operands are accepted on the same edge the output is consumed; no bubble is inserted.
- Arithmetic:
  - Default: unsigned. out_product = in_a * in_b exactly, 2*WIDTH bits, no overflow possible.
- busy: OR of all stage valid bits, including out_valid.
- Ordering: results emerge in acceptance order; none is dropped or duplicated.

Optional Feature:
- Macro: WALLACE_MULT_SIGNED_EN.
- Defined:
  - Operands and product are two's complement, using Baugh-Wooley partial-product generation (inverted MSB terms plus correction constant).
  - out_product is the exact signed 2*WIDTH-bit product.
- Undefined: unsigned only; no signed hardware is present.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 2 ops in flight, release -> out_valid=0, busy=0, out_product=0; no stale result ever emerges.
- Single op (WIDTH=8, PIPE_STAGES=2): in_a=0xFF, in_b=0xFF accepted at edge 0 -> out_valid=1 and out_product=0xFE01 after edge 2; busy drops after the consuming edge.
- Back-to-back: 16 consecutive ops (a=i, b=i+3), out_ready=1 -> 16 results in order, one per cycle, each = i*(i+3); in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, out_product held constant; release -> remaining results in order, none lost or duplicated.
- Boundary operands: (0,0xAB) -> 0x0000; (1,0xAB) -> 0x00AB; (0x80,0x02) -> 0x0100; random WIDTH=16, PIPE_STAGES=4 sweep matches the reference model.
- WALLACE_MULT_SIGNED_EN: (0x80,0x80) -> 0x4000; (0xFF,0x01) -> 0xFFFF; (0x7F,0x80) -> 0xC080; (0xFF,0xFF) -> 0x0001.
